// File: rtl/fp_sub_seq.sv
// Multi-cycle binary32 subtractor (a - b), truncating, valid/ready on both sides.
// Define FP_SUB_FAST_ALIGN_EN for single-cycle barrel-shift alignment.
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ALIGN, S_OP, S_NORM, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_a, r_bn;
    logic        r_sx, r_sy, r_sign;
    logic [7:0]  r_ex, r_d;
    logic [23:0] r_mx, r_my;
    logic [24:0] r_sum;
    logic [8:0]  r_exp;
    logic        r_in_ready, r_out_valid;
    logic [31:0] r_result;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Operand classification and special-case resolution
    logic [7:0]  w_a_exp, w_b_exp, w_ea, w_eb;
    logic [22:0] w_a_man, w_b_man;
    logic [23:0] w_ma, w_mb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_a_big;
    logic        w_spec_hit;
    logic [31:0] w_spec_res;

    assign w_a_exp  = r_a[30:23];
    assign w_b_exp  = r_bn[30:23];
    assign w_a_man  = r_a[22:0];
    assign w_b_man  = r_bn[22:0];
    assign w_a_nan  = (&w_a_exp) && (|w_a_man);
    assign w_b_nan  = (&w_b_exp) && (|w_b_man);
    assign w_a_inf  = (&w_a_exp) && !(|w_a_man);
    assign w_b_inf  = (&w_b_exp) && !(|w_b_man);
    assign w_a_zero = !(|r_a[30:0]);
    assign w_b_zero = !(|r_bn[30:0]);
    assign w_ea     = (w_a_exp == 8'd0) ? 8'd1 : w_a_exp;
    assign w_eb     = (w_b_exp == 8'd0) ? 8'd1 : w_b_exp;
    assign w_ma     = {(w_a_exp != 8'd0), w_a_man};
    assign w_mb     = {(w_b_exp != 8'd0), w_b_man};
    assign w_a_big  = {w_ea, w_ma} >= {w_eb, w_mb};

    always_comb begin
        w_spec_hit = 1'b1;
        w_spec_res = 32'h0;
        if (w_a_nan)                                    w_spec_res = r_a;
        else if (w_b_nan)                               w_spec_res = {~r_bn[31], r_bn[30:0]};
        else if (w_a_inf && w_b_inf && (r_a[31] != r_bn[31])) w_spec_res = 32'hFFC00000;
        else if (w_a_inf)                               w_spec_res = r_a;
        else if (w_b_inf)                               w_spec_res = r_bn;
        else if (w_a_zero)                              w_spec_res = r_bn;
        else if (w_b_zero)                              w_spec_res = r_a;
        else                                            w_spec_hit = 1'b0;
    end

    logic [24:0] w_sum;
    assign w_sum = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my})
                                  : ({1'b0, r_mx} - {1'b0, r_my});

    // One normalization step; finishes in the same cycle as the last needed shift
    logic [24:0] w_nsum;
    logic [8:0]  w_nexp;
    logic        w_n_done;
    logic [31:0] w_enc;

    always_comb begin
        w_nsum   = r_sum;
        w_nexp   = r_exp;
        w_n_done = 1'b1;
        if (r_sum[24]) begin
            w_nsum = {1'b0, r_sum[24:1]};
            w_nexp = r_exp + 9'd1;
        end else if (!r_sum[23] && (r_exp > 9'd1)) begin
            w_nsum   = {r_sum[23:0], 1'b0};
            w_nexp   = r_exp - 9'd1;
            w_n_done = w_nsum[23] || (w_nexp == 9'd1);
        end
        if (w_nexp >= 9'd255)
            w_enc = {r_sign, 8'hFF, 23'd0};
        else if (!w_nsum[23])
            w_enc = {r_sign, 8'd0, w_nsum[22:0]};
        else
            w_enc = {r_sign, w_nexp[7:0], w_nsum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_bn       <= {~b[31], b[30:0]};
                        r_in_ready <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_spec_hit) begin
                        r_result    <= w_spec_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        if (w_a_big) begin
                            r_sx <= r_a[31];  r_ex <= w_ea; r_mx <= w_ma;
                            r_sy <= r_bn[31]; r_my <= w_mb; r_d  <= w_ea - w_eb;
                        end else begin
                            r_sx <= r_bn[31]; r_ex <= w_eb; r_mx <= w_mb;
                            r_sy <= r_a[31];  r_my <= w_ma; r_d  <= w_eb - w_ea;
                        end
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
`ifdef FP_SUB_FAST_ALIGN_EN
                    r_my    <= (r_d >= 8'd25) ? 24'd0 : (r_my >> r_d);
                    r_d     <= 8'd0;
                    r_state <= S_OP;
`else
                    if (r_d == 8'd0) begin
                        r_state <= S_OP;
                    end else if (r_d >= 8'd25) begin
                        r_my    <= 24'd0;
                        r_d     <= 8'd0;
                        r_state <= S_OP;
                    end else begin
                        r_my <= r_my >> 1;
                        r_d  <= r_d - 8'd1;
                        if (r_d == 8'd1)
                            r_state <= S_OP;
                    end
`endif
                end
                S_OP: begin
                    if (w_sum == 25'd0) begin
                        r_result    <= 32'h0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_sum   <= w_sum;
                        r_exp   <= {1'b0, r_ex};
                        r_sign  <= r_sx;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_sum <= w_nsum;
                    r_exp <= w_nexp;
                    if (w_n_done) begin
                        r_result    <= w_enc;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed-vector bench for fp_sub_seq: results, latencies, handshake and reset.
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] a_i, b_i;
    logic        in_ready, out_valid;
    logic [31:0] result;
    int          total = 0;
    int          bad   = 0;

    fp_sub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;

`ifdef FP_SUB_FAST_ALIGN_EN
    localparam int LAT_D2 = 4;
`else
    localparam int LAT_D2 = 5;
`endif

    // Drives one operand pair and waits for the result; lat = -1 on timeout.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; a_i = ia; b_i = ib;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (out_valid) res = result;
        else begin res = 32'hDEADBEEF; lat = -1; end
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a_i = 32'h40400000; b_i = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] r; int l;
        run_op(32'h40400000, 32'h3F800000, r, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL basic_res: got %h want 40000000", r); end
        total++; if (l !== 4) begin bad++; $display("FAIL basic_lat: got %0d want 4", l); end
        run_op(32'h40800000, 32'h3F800000, r, l);
        total++; if (r !== 32'h40400000) begin bad++; $display("FAIL d2_res: got %h want 40400000", r); end
        total++; if (l !== LAT_D2) begin bad++; $display("FAIL d2_lat: got %0d want %0d", l, LAT_D2); end
        run_op(32'h3F800000, 32'hBF800000, r, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL carry_res: got %h want 40000000", r); end
        run_op(32'h00000003, 32'h00000001, r, l);
        total++; if (r !== 32'h00000002) begin bad++; $display("FAIL denorm_res: got %h want 00000002", r); end
        run_op(32'h3F800000, 32'h40000000, r, l);
        total++; if (r !== 32'hBF800000) begin bad++; $display("FAIL neg_res: got %h want bf800000", r); end
    endtask

    task automatic test_cancel();
        logic [31:0] r; int l;
        run_op(32'h3FC00000, 32'h3FC00000, r, l);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL cancel_zero: got %h want 00000000", r); end
        run_op(32'h3F800001, 32'h3F800000, r, l);
        total++; if (r !== 32'h34000000) begin bad++; $display("FAIL cancel_ulp: got %h want 34000000", r); end
        total++; if (l !== 26) begin bad++; $display("FAIL cancel_ulp_lat: got %0d want 26", l); end
    endtask

    task automatic test_specials();
        logic [31:0] r; int l;
        run_op(32'h7F800000, 32'h7F800000, r, l);
        total++; if (r !== 32'hFFC00000) begin bad++; $display("FAIL inf_inf: got %h want ffc00000", r); end
        total++; if (l !== 1) begin bad++; $display("FAIL inf_inf_lat: got %0d want 1", l); end
        run_op(32'h00000000, 32'h40000000, r, l);
        total++; if (r !== 32'hC0000000) begin bad++; $display("FAIL a_zero: got %h want c0000000", r); end
        run_op(32'h7FC00001, 32'h3F800000, r, l);
        total++; if (r !== 32'h7FC00001) begin bad++; $display("FAIL a_nan: got %h want 7fc00001", r); end
        total++; if (l !== 1) begin bad++; $display("FAIL a_nan_lat: got %0d want 1", l); end
        run_op(32'h3F800000, 32'hFFC00123, r, l);
        total++; if (r !== 32'hFFC00123) begin bad++; $display("FAIL b_nan: got %h want ffc00123", r); end
        run_op(32'h40A00000, 32'h00000000, r, l);
        total++; if (r !== 32'h40A00000) begin bad++; $display("FAIL b_zero: got %h want 40a00000", r); end
        run_op(32'h3F800000, 32'h7F800000, r, l);
        total++; if (r !== 32'hFF800000) begin bad++; $display("FAIL b_inf: got %h want ff800000", r); end
    endtask

    task automatic test_gap_overflow();
        logic [31:0] r; int l;
        run_op(32'h4B800000, 32'h33800000, r, l);
        total++; if (r !== 32'h4B800000) begin bad++; $display("FAIL gap_res: got %h want 4b800000", r); end
        total++; if (l !== 4) begin bad++; $display("FAIL gap_lat: got %0d want 4", l); end
        run_op(32'h7F7FFFFF, 32'hFF7FFFFF, r, l);
        total++; if (r !== 32'h7F800000) begin bad++; $display("FAIL overflow: got %h want 7f800000", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int l;
        out_ready = 1'b0;
        run_op(32'h40400000, 32'h3F800000, r, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL hold_res: got %h want 40000000", r); end
        in_valid = 1'b1; a_i = 32'h40800000; b_i = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || result !== 32'h40000000 || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable[%0d]: got v=%b r=%h rdy=%b want 1/40000000/0",
                                i, out_valid, result, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL done_exit: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reaccept: got rdy=%b want 0", in_ready); end
        l = 0;
        while (!out_valid && l < 200) begin @(posedge clk); #1; l++; end
        total++; if (result !== 32'h40400000 || l !== LAT_D2) begin
            bad++; $display("FAIL b2b_res: got %h lat %0d want 40400000 lat %0d", result, l, LAT_D2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int l; logic seen;
        in_valid = 1'b1; a_i = 32'h3F800001; b_i = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset: got v=%b r=%h rdy=%b want 0/00000000/1", out_valid, result, in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_abort: got out_valid seen=%b want 0", seen); end
        run_op(32'h40400000, 32'h3F800000, r, l);
        total++; if (r !== 32'h40000000) begin bad++; $display("FAIL post_reset: got %h want 40000000", r); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_i = 32'h0; b_i = 32'h0;
        test_reset();
        test_basic();
        test_cancel();
        test_specials();
        test_gap_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
